// File: rtl/net_drive_arbiter.sv
// Round-robin owner of a shared net: one registered grant at a time, a forced
// hand-off after MAX_HOLD cycles, and a one-cycle bus-released gap between owners.
module net_drive_arbiter #(
  parameter int N        = 4,
  parameter int DW       = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req,
  input  logic [N*DW-1:0]       req_data,
  output logic [N-1:0]          gnt,
  output logic                  bus_oe,
  output logic [DW-1:0]         bus_data,
  output logic [$clog2(N)-1:0]  owner,
  output logic                  hold_timeout
);
  localparam int OW = $clog2(N);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t         state_q, state_d;
  logic [OW-1:0]  ptr_q, ptr_d;
  logic [7:0]     hold_q, hold_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [OW-1:0]  owner_q, owner_d;
  logic           timeout_q, timeout_d;

  logic           found;
  logic [OW-1:0]  win;
  logic [OW-1:0]  ptr_next;

  // Walk downward so the last hit written is the one closest to ptr.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % N;
      if (req[idx]) begin
        found = 1'b1;
        win   = OW'(idx);
      end
    end
  end

  assign ptr_next = (owner_q == OW'(N - 1)) ? '0 : owner_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      gnt_q     <= '0;
      owner_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE, TURN: begin
        state_d = IDLE;
        gnt_d   = '0;
        owner_d = '0;
        hold_d  = '0;
        if (found) begin
          state_d = GRANT;
          gnt_d   = {{(N-1){1'b0}}, 1'b1} << win;
          owner_d = win;
          hold_d  = 8'd1;
        end
      end
      GRANT: begin
        // A drop wins over a coincident timeout, so no pulse in that case.
        if (!req[owner_q] || hold_q == 8'(MAX_HOLD)) begin
          state_d   = TURN;
          gnt_d     = '0;
          owner_d   = '0;
          hold_d    = '0;
          ptr_d     = ptr_next;
          timeout_d = req[owner_q];
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus_oe   = (state_q == GRANT);
    bus_data = '0;
    owner    = '0;
    if (state_q == GRANT) begin
      bus_data = req_data[int'(owner_q)*DW +: DW];
      owner    = owner_q;
    end
  end

  assign gnt          = gnt_q;
  assign hold_timeout = timeout_q;

endmodule

// File: tb/tb_net_drive_arbiter.sv
// Directed vectors push expected outputs into a cycle-tagged queue; a negedge
// monitor pops and compares them and also checks the bus-sharing invariants.
module tb_net_drive_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        bus_oe;
  logic [7:0]  bus_data;
  logic [1:0]  owner;
  logic        hold_timeout;

  logic [7:0] dtab [4] = '{8'h17, 8'h5C, 8'hA5, 8'hD3};
  assign req_data = {dtab[3], dtab[2], dtab[1], dtab[0]};

  net_drive_arbiter #(.N(4), .DW(8), .MAX_HOLD(16)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .gnt(gnt), .bus_oe(bus_oe), .bus_data(bus_data), .owner(owner),
    .hold_timeout(hold_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] gnt;
    logic       to;
  } exp_t;

  exp_t exp_q [$];
  int   cyc = 0;
  int   vecs = 0;
  int   errs = 0;
  logic [3:0] prev_gnt = 4'b0000;
  logic       prev_oe  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Drive one vector; its response is visible after the next rising edge.
  task automatic drv(input logic r, input logic [3:0] rq, input logic [3:0] eg, input logic et);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    req = rq;
    e.cyc = cyc + 1;
    e.gnt = eg;
    e.to  = et;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t       e;
    logic [1:0] eo;
    logic [7:0] ed;
    if (cyc > 0) begin
      vecs++;
      if (!(gnt == 4'b0000 || gnt == 4'b0001 || gnt == 4'b0010 || gnt == 4'b0100 || gnt == 4'b1000)
          || bus_oe !== (|gnt) || (!bus_oe && (bus_data !== 8'h00 || owner !== 2'd0))
          || (prev_oe && bus_oe && gnt !== prev_gnt)) begin
        errs++;
        $display("FAIL invariant cyc=%0d gnt=%b oe=%b data=%h owner=%0d prev_gnt=%b", cyc, gnt, bus_oe, bus_data, owner, prev_gnt);
      end
      prev_gnt = gnt;
      prev_oe  = bus_oe;
    end
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      vecs++;
      eo = 2'd0;
      for (int i = 0; i < 4; i++) if (e.gnt[i]) eo = 2'(i);
      ed = (e.gnt != 4'b0000) ? dtab[eo] : 8'h00;
      if (e.cyc != cyc || gnt !== e.gnt || bus_oe !== (|e.gnt) || owner !== eo
          || bus_data !== ed || hold_timeout !== e.to) begin
        errs++;
        $display("FAIL vector cyc=%0d(exp %0d) got gnt=%b oe=%b owner=%0d data=%h to=%b want gnt=%b oe=%b owner=%0d data=%h to=%b",
                 cyc, e.cyc, gnt, bus_oe, owner, bus_data, hold_timeout, e.gnt, |e.gnt, eo, ed, e.to);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // reset holds everything at zero even with all requests up
    drv(1, 4'b1111, 4'b0000, 0);
    drv(1, 4'b1111, 4'b0000, 0);
    // single requester 2
    drv(0, 4'b0100, 4'b0100, 0);
    drv(0, 4'b0100, 4'b0100, 0);
    drv(0, 4'b0000, 4'b0000, 0);
    drv(0, 4'b0000, 4'b0000, 0);
    // round robin 0,1,2,3,0; reset must bring ptr back to 0
    drv(1, 4'b0000, 4'b0000, 0);
    drv(0, 4'b1111, 4'b0001, 0);
    drv(0, 4'b1111, 4'b0001, 0);
    drv(0, 4'b1110, 4'b0000, 0);
    drv(0, 4'b1111, 4'b0010, 0);
    drv(0, 4'b1111, 4'b0010, 0);
    drv(0, 4'b1101, 4'b0000, 0);
    drv(0, 4'b1111, 4'b0100, 0);
    drv(0, 4'b1111, 4'b0100, 0);
    drv(0, 4'b1011, 4'b0000, 0);
    drv(0, 4'b1111, 4'b1000, 0);
    drv(0, 4'b1111, 4'b1000, 0);
    drv(0, 4'b0111, 4'b0000, 0);
    drv(0, 4'b1111, 4'b0001, 0);
    drv(0, 4'b0000, 4'b0000, 0);
    drv(0, 4'b0000, 4'b0000, 0);
    // lone requester times out and is re-granted after the gap
    drv(1, 4'b0000, 4'b0000, 0);
    repeat (16) drv(0, 4'b0001, 4'b0001, 0);
    drv(0, 4'b0001, 4'b0000, 1);
    drv(0, 4'b0001, 4'b0001, 0);
    drv(0, 4'b0000, 4'b0000, 0);
    drv(0, 4'b0000, 4'b0000, 0);
    // timeout with a competitor: 0 then 1 then back to 0
    drv(1, 4'b0000, 4'b0000, 0);
    repeat (16) drv(0, 4'b0011, 4'b0001, 0);
    drv(0, 4'b0011, 4'b0000, 1);
    repeat (16) drv(0, 4'b0011, 4'b0010, 0);
    drv(0, 4'b0011, 4'b0000, 1);
    drv(0, 4'b0011, 4'b0001, 0);
    drv(0, 4'b0000, 4'b0000, 0);
    drv(0, 4'b0000, 4'b0000, 0);
    // drop coincident with the timeout cycle gives no pulse
    drv(1, 4'b0000, 4'b0000, 0);
    repeat (16) drv(0, 4'b0001, 4'b0001, 0);
    drv(0, 4'b0000, 4'b0000, 0);
    drv(0, 4'b0000, 4'b0000, 0);
    // others toggling mid-grant are ignored; reset in 5th grant cycle
    drv(1, 4'b0000, 4'b0000, 0);
    drv(0, 4'b1111, 4'b0001, 0);
    drv(0, 4'b0001, 4'b0001, 0);
    drv(0, 4'b1011, 4'b0001, 0);
    drv(0, 4'b0101, 4'b0001, 0);
    drv(0, 4'b0001, 4'b0001, 0);
    drv(1, 4'b0001, 4'b0000, 0);
    drv(0, 4'b1000, 4'b1000, 0);
    drv(0, 4'b0000, 4'b0000, 0);
    drv(0, 4'b0000, 4'b0000, 0);
    repeat (3) @(posedge clk);
    vecs++;
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
